// File: rtl/seq_match_ctrl.sv
// Run-time programmable serial pattern detector: holds pattern/len/overlap/threshold
// config, arms with start, pulses match per detected pattern and halts at threshold.
module seq_match_ctrl #(
    parameter  int MAX_LEN = 8,
    parameter  int CNT_W   = 8,
    localparam int LEN_W   = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic [CNT_W-1:0]   cfg_threshold,
    input  logic               start,
    input  logic               stop,
    input  logic               din_valid,
    input  logic               din,
    output logic               busy,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic               done,
    output logic               cfg_err,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [CNT_W-1:0]   thr_q, thr_d;
    logic [MAX_LEN-1:0] sr_q, sr_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               match_q, match_d;
    logic               cfg_err_q, cfg_err_d;

    logic               len_legal, cfg_ok, run_entry, beat, hit, hit_thr;
    logic [MAX_LEN-1:0] sr_shift, len_mask;
    logic [LEN_W-1:0]   fill_inc;
    logic [CNT_W-1:0]   cnt_inc;

    // A beat on a stop cycle is dropped: the run is ending and its prefix is discarded.
    always_comb begin
        len_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
        cfg_ok    = cfg_we && (state_q != S_RUN) && len_legal;
        run_entry = (state_q != S_RUN) && start;
        beat      = (state_q == S_RUN) && !stop && din_valid;
        sr_shift  = {sr_q[MAX_LEN-2:0], din};
        fill_inc  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);
        len_mask  = ~({MAX_LEN{1'b1}} << len_q);
        hit       = (fill_inc >= len_q) && ((sr_shift & len_mask) == (pat_q & len_mask));
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        hit_thr   = beat && hit && (thr_q != '0) && (cnt_inc == thr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (stop)         state_d = S_IDLE;
                else if (hit_thr) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == S_RUN);
        done      = (state_q == S_DONE);
        dbg_state = state_q;
    end

    // Config commits on the same edge as start, so a new run sees the new config.
    always_comb begin
        pat_d     = pat_q;
        len_d     = len_q;
        ovl_d     = ovl_q;
        thr_d     = thr_q;
        sr_d      = sr_q;
        fill_d    = fill_q;
        cnt_d     = cnt_q;
        match_d   = beat && hit;
        cfg_err_d = cfg_we && ((state_q == S_RUN) || !len_legal);
        if (cfg_ok) begin
            pat_d = cfg_pattern;
            len_d = cfg_len;
            ovl_d = cfg_overlap;
            thr_d = cfg_threshold;
        end
        if (run_entry) begin
            sr_d   = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (beat) begin
            sr_d   = sr_shift;
            fill_d = (hit && !ovl_q) ? '0 : fill_inc;
            if (hit) cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q     <= '0;
            len_q     <= LEN_W'(1);
            ovl_q     <= 1'b1;
            thr_q     <= '0;
            sr_q      <= '0;
            fill_q    <= '0;
            cnt_q     <= '0;
            match_q   <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            pat_q     <= pat_d;
            len_q     <= len_d;
            ovl_q     <= ovl_d;
            thr_q     <= thr_d;
            sr_q      <= sr_d;
            fill_q    <= fill_d;
            cnt_q     <= cnt_d;
            match_q   <= match_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign match       = match_q;
    assign match_count = cnt_q;
    assign cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_seq_match_ctrl.sv
// Scoreboard bench for seq_match_ctrl: expected {done,count} per match pulse is queued
// by the stimulus and popped by a negedge monitor.
module tb_seq_match_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic [7:0] cfg_threshold = '0;
    logic       start = 1'b0, stop = 1'b0, din_valid = 1'b0, din = 1'b0;
    logic       busy, match, done, cfg_err;
    logic [7:0] match_count;
    logic [1:0] dbg_state;

    logic       s_cfg_we = 1'b0, s_start = 1'b0, s_din_valid = 1'b0, s_din = 1'b0;
    logic       s_busy, s_match, s_done, s_cfg_err;
    logic [1:0] s_count, s_dbg_state;

    int checks = 0;
    int errors = 0;
    logic [8:0] exp_q[$];

    always #5 clk = ~clk;

    seq_match_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_pattern(cfg_pattern),
        .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_threshold(cfg_threshold),
        .start(start), .stop(stop), .din_valid(din_valid), .din(din),
        .busy(busy), .match(match), .match_count(match_count), .done(done),
        .cfg_err(cfg_err), .dbg_state(dbg_state)
    );

    seq_match_ctrl #(.MAX_LEN(8), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .cfg_we(s_cfg_we), .cfg_pattern(8'h01),
        .cfg_len(4'd1), .cfg_overlap(1'b1), .cfg_threshold(2'd0),
        .start(s_start), .stop(1'b0), .din_valid(s_din_valid), .din(s_din),
        .busy(s_busy), .match(s_match), .match_count(s_count), .done(s_done),
        .cfg_err(s_cfg_err), .dbg_state(s_dbg_state)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every match pulse must correspond to a queued expectation.
    always @(negedge clk) begin
        if (rst_n && match) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_match: got count=%0d done=%0d expected no match", match_count, done);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({done, match_count} != e) begin
                    errors++;
                    $display("FAIL match_pulse: got done=%0d count=%0d expected done=%0d count=%0d",
                             done, match_count, e[8], e[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        din_valid = 1'b1;
        din = b;
        tick();
        din_valid = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] bits, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) begin
            send_bit(bits[i]);
            repeat (gap) tick();
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic cfg_write(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                             input logic [7:0] thr, input logic with_start);
        cfg_we = 1'b1;
        cfg_pattern = pat;
        cfg_len = len;
        cfg_overlap = ovl;
        cfg_threshold = thr;
        start = with_start;
        tick();
        cfg_we = 1'b0;
        start = 1'b0;
    endtask

    task automatic expect_match(input logic d, input logic [7:0] cnt);
        exp_q.push_back({d, cnt});
    endtask

    task automatic drain(input string name);
        idle_cycles(3);
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        idle_cycles(3);
        check("rst_busy", busy, 0);
        check("rst_match", match, 0);
        check("rst_count", match_count, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic: 1000, len 4, threshold 2
        cfg_write(8'b0000_1000, 4'd4, 1'b1, 8'd2, 1'b0);
        check("basic_cfg_err", cfg_err, 0);
        pulse_start();
        check("basic_busy", busy, 1);
        expect_match(1'b0, 8'd1);
        expect_match(1'b1, 8'd2);
        send_bits(8'b1000_1000, 8, 0);
        check("basic_done", done, 1);
        check("basic_busy_off", busy, 0);
        send_bits(8'b1000_1000, 8, 0);
        drain("basic_drain");
        check("basic_count_held", match_count, 2);

        // Overlap on: 101 in 10101 -> two matches
        cfg_write(8'b101, 4'd3, 1'b1, 8'd0, 1'b0);
        pulse_start();
        expect_match(1'b0, 8'd1);
        expect_match(1'b0, 8'd2);
        send_bits(8'b1_0101, 5, 0);
        drain("ovl1_drain");
        check("ovl1_busy", busy, 1);
        check("ovl1_count", match_count, 2);
        pulse_stop();
        check("stop_idle", busy, 0);
        check("stop_count_kept", match_count, 2);

        // Overlap off: only one match
        cfg_write(8'b101, 4'd3, 1'b0, 8'd0, 1'b0);
        pulse_start();
        expect_match(1'b0, 8'd1);
        send_bits(8'b1_0101, 5, 0);
        drain("ovl0_drain");
        check("ovl0_count", match_count, 1);
        pulse_stop();

        // Valid gating: three idle cycles between bits
        cfg_write(8'b0000_1000, 4'd4, 1'b1, 8'd2, 1'b0);
        pulse_start();
        expect_match(1'b0, 8'd1);
        expect_match(1'b1, 8'd2);
        send_bits(8'b1000_1000, 8, 3);
        drain("gate_drain");
        check("gate_done", done, 1);
        check("gate_count", match_count, 2);

        // Illegal lengths rejected, old config kept
        cfg_write(8'b101, 4'd0, 1'b1, 8'd0, 1'b0);
        check("len0_err", cfg_err, 1);
        tick();
        check("err_pulse_one_cycle", cfg_err, 0);
        cfg_write(8'b101, 4'd9, 1'b1, 8'd0, 1'b0);
        check("len9_err", cfg_err, 1);
        pulse_start();
        expect_match(1'b0, 8'd1);
        expect_match(1'b1, 8'd2);
        send_bits(8'b1000_1000, 8, 0);
        drain("old_cfg_drain");

        // Write during RUN rejected
        pulse_start();
        cfg_write(8'b101, 4'd3, 1'b1, 8'd0, 1'b0);
        check("run_we_err", cfg_err, 1);
        expect_match(1'b0, 8'd1);
        send_bits(8'b1000, 4, 0);
        drain("run_we_drain");
        pulse_stop();

        // Config write and start together: run uses new config
        cfg_write(8'b101, 4'd3, 1'b1, 8'd0, 1'b1);
        check("we_start_busy", busy, 1);
        check("we_start_err", cfg_err, 0);
        expect_match(1'b0, 8'd1);
        send_bits(8'b101, 3, 0);
        drain("we_start_drain");
        pulse_stop();

        // Stop/restart discards the prefix and clears the count
        cfg_write(8'b0000_1000, 4'd4, 1'b1, 8'd0, 1'b0);
        pulse_start();
        check("restart_count_clr", match_count, 0);
        send_bits(8'b10, 2, 0);
        pulse_stop();
        pulse_start();
        send_bits(8'b00, 2, 0);
        drain("restart_drain");
        check("restart_count", match_count, 0);

        // start in RUN is ignored: the prefix survives
        send_bits(8'b10, 2, 0);
        pulse_start();
        expect_match(1'b0, 8'd1);
        send_bits(8'b00, 2, 0);
        drain("start_ign_drain");

        // start and stop together in RUN: stop wins
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        check("start_stop_busy", busy, 0);
        check("start_stop_state", dbg_state, 0);

        // Saturation: CNT_W=2, len 1 pattern 1, eight 1-beats
        s_cfg_we = 1'b1;
        s_start = 1'b1;
        tick();
        s_cfg_we = 1'b0;
        s_start = 1'b0;
        check("sat_busy", s_busy, 1);
        for (int i = 0; i < 8; i++) begin
            s_din_valid = 1'b1;
            s_din = 1'b1;
            tick();
            check("sat_match", s_match, 1);
            check("sat_count", s_count, (i + 1 > 3) ? 3 : i + 1);
        end
        s_din_valid = 1'b0;
        tick();
        check("sat_match_off", s_match, 0);
        check("sat_not_done", s_done, 0);

        // Async reset mid-run
        pulse_start();
        send_bit(1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_state", dbg_state, 0);
        check("arst_sat_count", s_count, 0);
        check("arst_sat_busy", s_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Config lost: defaults are len 1, pattern 0
        pulse_start();
        expect_match(1'b0, 8'd1);
        send_bit(1'b0);
        send_bit(1'b1);
        drain("default_cfg_drain");
        check("default_cfg_count", match_count, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_match_ctrl.md
Name: seq_match_ctrl

Overview:
Run-time controller for serial bit-pattern detection. Holds a programmable pattern of up to MAX_LEN bits, a pattern length, an overlap mode and a match threshold, and arms and disarms detection with start/stop. While running it matches the gated serial stream, pulses on each match and counts matches. It halts in DONE once the threshold is reached. It replaces hard-coded per-pattern Moore detectors in the sequence-detector subsystem.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
CNT_W, 8, width of match counter and threshold
LEN_W, $clog2(MAX_LEN+1), width of cfg_len (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
cfg_we  in  1  configuration write strobe
cfg_pattern  in  MAX_LEN  pattern; bit [len-1] is first received, bit [0] is last
cfg_len  in  LEN_W  pattern length, legal 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches allowed
cfg_threshold  in  CNT_W  match count that ends the run; 0 = free-run
start  in  1  arm detection (pulse)
stop  in  1  disarm detection (pulse)
din_valid  in  1  din qualifier
din  in  1  serial data bit
busy  out  1  high in RUN
match  out  1  one-cycle pulse per detected pattern
match_count  out  CNT_W  matches since last start, saturating
done  out  1  high while in DONE
cfg_err  out  1  one-cycle pulse on rejected cfg_we

Behaviour:
- Reset values:
  - All outputs: 0.
  - State: IDLE.
  - Config registers: pattern=0, len=1, overlap=1, threshold=0.
  - Shift register and fill count: 0.
- States:
  - IDLE: start -> RUN.
  - RUN: stop -> IDLE; threshold reached -> DONE.
  - DONE: start -> RUN.
- Start/stop rules:
  - start in RUN is ignored.
  - start and stop in the same RUN cycle: stop wins.
  - On entry to RUN: shift register, fill count and match_count are cleared.
  - RUN -> IDLE via stop: match_count is retained; partial prefix is discarded.
- Config writes:
  - Accepted only in IDLE or DONE.
  - cfg_we in RUN: ignored, cfg_err=1 next cycle.
  - cfg_len==0 or cfg_len>MAX_LEN: whole write rejected, registers unchanged, cfg_err=1 next cycle.
  - cfg_we and start in the same IDLE/DONE cycle: both accepted; the run uses the new config. If the write is illegal, start is still accepted with the old config.
- Matching (RUN only):
  - Only on cycles with din_valid=1.
  - sr <= {sr[MAX_LEN-2:0], din}; fill <= min(fill+1, MAX_LEN).
  - Beat completes a match when, after the shift, fill>=len and sr[len-1:0]==pattern[len-1:0].
  - Cycles with din_valid=0 change nothing.
- Match outputs:
  - match is registered: high exactly one cycle, the cycle after the completing beat.
  - match_count increments on the same edge; saturates at 2^CNT_W-1.
- Overlap mode:
  - overlap=1: fill is unchanged after a match, so a suffix can start the next match.
  - overlap=0: fill is forced to 0 on a match, so the next match needs len fresh bits.
- Threshold:
  - If threshold!=0 and the increment makes match_count==threshold, enter DONE on the same edge. match and done rise together.
  - Input bits are ignored in DONE.
- Outputs: busy is 1 iff state==RUN; done is 1 iff state==DONE.
- Async reset mid-run: immediate return to reset values; config is lost.
- len==1: every valid beat equal to pattern[0] matches; overlap mode is irrelevant.

Test Plan:
- Basic: cfg pattern=8'b0000_1000, len=4, overlap=1, threshold=2; start; din 1,0,0,0,1,0,0,0 each valid -> match pulse one cycle after beats 4 and 8; count 1 then 2; done=1, busy=0 after beat 8; further din ignored.
- Overlap: pattern=3'b101, len=3, threshold=0; stream 1,0,1,0,1 -> overlap=1: 2 matches (beats 3,5), count=2. overlap=0: 1 match (beat 3), count=1. busy stays 1.
- Valid gating: basic config with din_valid low for 3 cycles between every bit -> same match timing relative to valid beats; count=2.
- Config errors: cfg_len=0 -> cfg_err pulse, subsequent run still detects the old pattern. cfg_we in RUN -> cfg_err pulse, config unchanged.
- Stop/restart: feed 1,0; stop; start; feed 0,0 -> no match. Count is cleared on start. start+stop in the same RUN cycle -> IDLE.
- Saturation and reset: CNT_W=2, threshold=0, pattern len=1 bit 1, eight 1-beats -> count saturates at 3. Assert rst_n mid-run -> all outputs 0, IDLE.
